// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, opcodes, data width,
// ID/EX bundle and the operand-stage FSM encoding.
package pipeline_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        FwdRegFile        = 2'd0,
        FwdEX_ALUResult   = 2'd1,
        FwdMEM_ALUResult  = 2'd2,
        FwdMEM_MemoryRead = 2'd3
    } fwd_sel_e;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] ALU = 4'd1;
    localparam logic [3:0] LW  = 4'd2;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } op_state_e;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [3:0]        rd;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
    } id_ex_t;

endpackage

// File: rtl/operand_forward_mux.sv
// 4:1 forwarding select for one execute-stage operand.
// Pure routing: the chosen source passes through unmodified.
module operand_forward_mux
    import pipeline_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_read,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = reg_data;
        unique case (fwd_sel_e'(sel))
            FwdRegFile:        operand = reg_data;
            FwdEX_ALUResult:   operand = ex_alu;
            FwdMEM_ALUResult:  operand = mem_alu;
            FwdMEM_MemoryRead: operand = mem_read;
            default:           operand = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding and one-bubble load-use stall.
// Optional saturating stall counter built when STALL_COUNTER_EN is defined.
module id_ex_operand_stage
    import pipeline_pkg::*;
(
    input  logic        ClockInput,
    input  logic        ResetInputN,
    input  logic        ID_Valid,
    input  logic [3:0]  ID_OpCode,
    input  logic [3:0]  ID_Rdestination,
    input  logic [15:0] ID_RegPrimary,
    input  logic [15:0] ID_RegSecondary,
    input  logic [1:0]  ID_FwdPrimary,
    input  logic [1:0]  ID_FwdSecondary,
    input  logic        StallRequest,
    input  logic        FlushRequest,
    input  logic [15:0] EX_ALUResult,
    input  logic [15:0] MEM_ALUResult,
    input  logic [15:0] MEM_MemoryRead,
    output logic        EX_Valid,
    output logic [3:0]  EX_OpCode,
    output logic [3:0]  EX_Rdestination,
    output logic [15:0] EX_OperandPrimary,
    output logic [15:0] EX_OperandSecondary,
    output logic        ID_Hold
`ifdef STALL_COUNTER_EN
    ,
    output logic [15:0] StallCount
`endif
);

    op_state_e         state;
    op_state_e         state_nxt;
    id_ex_t            ex_q;
    id_ex_t            ex_nxt;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              do_flush;
    logic              do_stall;
    logic              do_idle;
    logic              do_take;

    operand_forward_mux u_fwd_a (
        .sel      (ID_FwdPrimary),
        .reg_data (ID_RegPrimary),
        .ex_alu   (EX_ALUResult),
        .mem_alu  (MEM_ALUResult),
        .mem_read (MEM_MemoryRead),
        .operand  (fwd_a)
    );

    operand_forward_mux u_fwd_b (
        .sel      (ID_FwdSecondary),
        .reg_data (ID_RegSecondary),
        .ex_alu   (EX_ALUResult),
        .mem_alu  (MEM_ALUResult),
        .mem_read (MEM_MemoryRead),
        .operand  (fwd_b)
    );

    // Mutually exclusive edge actions; flush outranks everything.
    assign do_flush = FlushRequest;
    assign do_stall = !FlushRequest && StallRequest && (state == RUN);
    assign do_idle  = !FlushRequest && !do_stall && !ID_Valid;
    assign do_take  = !FlushRequest && !do_stall && ID_Valid;

    assign ID_Hold = ResetInputN && do_stall;

    always_comb begin
        state_nxt = state;
        ex_nxt    = '0;
        unique case (1'b1)
            do_flush: state_nxt = RUN;
            do_stall: state_nxt = BUBBLE;
            do_idle:  state_nxt = state;
            do_take: begin
                state_nxt = RUN;
                ex_nxt    = '{valid:  1'b1,
                              opcode: ID_OpCode,
                              rd:     ID_Rdestination,
                              op_a:   fwd_a,
                              op_b:   fwd_b};
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            state <= RUN;
            ex_q  <= '0;
        end else begin
            state <= state_nxt;
            ex_q  <= ex_nxt;
        end
    end

    assign EX_Valid            = ex_q.valid;
    assign EX_OpCode           = ex_q.opcode;
    assign EX_Rdestination     = ex_q.rd;
    assign EX_OperandPrimary   = ex_q.op_a;
    assign EX_OperandSecondary = ex_q.op_b;

`ifdef STALL_COUNTER_EN
    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            StallCount <= '0;
        end else if (ID_Hold && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, reset corners,
// then random traffic against a rule-level model (define STALL_COUNTER_EN to cover StallCount).
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [3:0]  id_rd;
    logic [15:0] id_rp;
    logic [15:0] id_rs;
    logic [1:0]  id_fp;
    logic [1:0]  id_fs;
    logic        stall;
    logic        flush;
    logic [15:0] ex_alu;
    logic [15:0] mem_alu;
    logic [15:0] mem_rd;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic        id_hold;
`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .ClockInput          (clk),
        .ResetInputN         (rst_n),
        .ID_Valid            (id_valid),
        .ID_OpCode           (id_op),
        .ID_Rdestination     (id_rd),
        .ID_RegPrimary       (id_rp),
        .ID_RegSecondary     (id_rs),
        .ID_FwdPrimary       (id_fp),
        .ID_FwdSecondary     (id_fs),
        .StallRequest        (stall),
        .FlushRequest        (flush),
        .EX_ALUResult        (ex_alu),
        .MEM_ALUResult       (mem_alu),
        .MEM_MemoryRead      (mem_rd),
        .EX_Valid            (ex_valid),
        .EX_OpCode           (ex_op),
        .EX_Rdestination     (ex_rd),
        .EX_OperandPrimary   (ex_a),
        .EX_OperandSecondary (ex_b),
        .ID_Hold             (id_hold)
`ifdef STALL_COUNTER_EN
        ,
        .StallCount          (stall_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] rp;
        logic [15:0] rs;
        logic [1:0]  fp;
        logic [1:0]  fs;
        logic [15:0] exr;
        logic [15:0] mar;
        logic [15:0] mmr;
        logic        st;
        logic        fl;
        logic        e_hold;
        logic [40:0] e_ex;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        logic v, logic [3:0] op, logic [3:0] rd,
        logic [15:0] rp, logic [15:0] rs,
        logic [1:0] fp, logic [1:0] fs,
        logic [15:0] exr, logic [15:0] mar, logic [15:0] mmr,
        logic st, logic fl, logic eh,
        logic ev, logic [3:0] eop, logic [3:0] erd,
        logic [15:0] ea, logic [15:0] eb);
        vec_t t;
        t.v = v; t.op = op; t.rd = rd; t.rp = rp; t.rs = rs;
        t.fp = fp; t.fs = fs; t.exr = exr; t.mar = mar; t.mmr = mmr;
        t.st = st; t.fl = fl; t.e_hold = eh;
        t.e_ex = {ev, eop, erd, ea, eb};
        return t;
    endfunction

    function automatic logic [40:0] ex_now();
        return {ex_valid, ex_op, ex_rd, ex_a, ex_b};
    endfunction

    task automatic chk(input string name, input logic [40:0] act,
                       input logic [40:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_op = t.op; id_rd = t.rd;
        id_rp = t.rp; id_rs = t.rs; id_fp = t.fp; id_fs = t.fs;
        ex_alu = t.exr; mem_alu = t.mar; mem_rd = t.mmr;
        stall = t.st; flush = t.fl;
    endtask

    // Inputs change 1 time unit after the edge; hold is checked before the
    // next edge and EX 1 time unit after it.
    task automatic apply(input vec_t t, input string tag);
        drive(t);
        #1;
        chk({tag, "_hold"}, 41'(id_hold), 41'(t.e_hold));
        if (t.e_hold) m_cnt++;
        @(posedge clk);
        #1;
        chk({tag, "_ex"}, ex_now(), t.e_ex);
    endtask

    initial begin
        vec_t        z;
        logic        m_bub;
        logic        e_hold;
        logic [40:0] e_ex;
        logic [15:0] src_a[4];
        logic [15:0] src_b[4];

        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0);
        vecs[0]  = mk(1, 1, 3, 16'h0011, 16'h0022, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 1, 3, 16'h0011, 16'h0022);
        vecs[1]  = mk(1, 1, 4, 16'h0001, 16'h0002, 1, 2,
                      16'hAAAA, 16'h5555, 0, 0, 0,
                      0, 1, 1, 4, 16'hAAAA, 16'h5555);
        vecs[2]  = mk(1, 2, 5, 16'h1234, 16'h5678, 0, 0, 0, 0, 0, 1, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 2, 5, 16'h1234, 16'h5678, 3, 0,
                      0, 0, 16'hBEEF, 0, 0,
                      0, 1, 2, 5, 16'hBEEF, 16'h5678);
        vecs[4]  = mk(1, 1, 6, 16'h0101, 16'h0202, 0, 0, 0, 0, 0, 1, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 6, 16'h0101, 16'h0202, 0, 0, 0, 0, 0, 1, 0,
                      0, 1, 1, 6, 16'h0101, 16'h0202);
        vecs[6]  = mk(1, 1, 7, 16'h0707, 16'h0808, 0, 0, 0, 0, 0, 1, 1,
                      0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 7, 16'h0707, 16'h0808, 0, 0, 0, 0, 0, 1, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 7, 16'h0707, 16'h0808, 0, 0, 0, 0, 0, 0, 0,
                      0, 1, 1, 7, 16'h0707, 16'h0808);
        vecs[9]  = mk(0, 1, 8, 16'h1111, 16'h2222, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 9, 15, 16'h0000, 16'h0000, 2, 3,
                      16'h0F0F, 16'h5A5A, 16'hC3C3, 0, 0,
                      0, 1, 9, 15, 16'h5A5A, 16'hC3C3);
        vecs[11] = mk(1, 1, 1, 16'h3333, 16'h4444, 0, 0, 0, 0, 0, 1, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 1, 1, 16'h3333, 16'h4444, 0, 0, 0, 0, 0, 0, 1,
                      0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 1, 2, 16'h3333, 16'h4444, 0, 0, 0, 0, 0, 1, 0,
                      1, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 2, 16'h3333, 16'h4444, 1, 1,
                      16'h7777, 0, 0, 0, 0,
                      0, 1, 1, 2, 16'h7777, 16'h7777);

        // Power-on reset with a stall pending: hold must stay low.
        rst_n = 1'b0;
        drive(z);
        stall = 1'b1;
        #3;
        chk("por_ex", ex_now(), '0);
        chk("por_hold", 41'(id_hold), 41'(0));
`ifdef STALL_COUNTER_EN
        chk("por_cnt", 41'(stall_cnt), 41'(0));
`endif
        stall = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Random traffic against a rule-level model.
        m_bub = 1'b0;
        for (int i = 0; i < 400; i++) begin
            id_rp = 16'($urandom); id_rs = 16'($urandom);
            ex_alu = 16'($urandom); mem_alu = 16'($urandom);
            mem_rd = 16'($urandom);
            id_fp = 2'($urandom); id_fs = 2'($urandom);
            id_op = 4'($urandom); id_rd = 4'($urandom);
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_valid = stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            src_a = '{id_rp, ex_alu, mem_alu, mem_rd};
            src_b = '{id_rs, ex_alu, mem_alu, mem_rd};
            e_hold = stall && !m_bub && !flush;
            e_ex = '0;
            if (flush) begin
                m_bub = 1'b0;
            end else if (e_hold) begin
                m_bub = 1'b1;
            end else if (id_valid) begin
                m_bub = 1'b0;
                e_ex = {1'b1, id_op, id_rd, src_a[id_fp], src_b[id_fs]};
            end
            if (e_hold && m_cnt < 65535) m_cnt++;
            #1;
            chk($sformatf("rnd%0d_hold", i), 41'(id_hold), 41'(e_hold));
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_ex", i), ex_now(), e_ex);
        end
`ifdef STALL_COUNTER_EN
        chk("cnt_total", 41'(stall_cnt), 41'(m_cnt));
`endif

        // Reset asserted while in BUBBLE with a stall still requested.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstb_ex", ex_now(), '0);
        chk("rstb_hold", 41'(id_hold), 41'(0));
`ifdef STALL_COUNTER_EN
        chk("rstb_cnt", 41'(stall_cnt), 41'(0));
`endif
        #1 rst_n = 1'b1;
        #1;
        chk("rstb_run", 41'(id_hold), 41'(1));
        // Stall held: RUN/BUBBLE alternate, giving 3 hold cycles in 5 edges.
        repeat (5) @(posedge clk);
        #1;
        stall = 1'b0;
`ifdef STALL_COUNTER_EN
        chk("cnt_three", 41'(stall_cnt), 41'(3));
`endif

        // Asynchronous clear of a live instruction between edges.
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("live_ex", ex_now(), vecs[1].e_ex);
        rst_n = 1'b0;
        #1;
        chk("rstr_ex", ex_now(), '0);
        #1 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
